// File: rtl/icache_ctrl.sv
// -----------------------------------------------------------------------------
// icache_ctrl
//
// Direct-mapped, read-only instruction cache between the fetch stage and the
// backing instruction memory. One line holds one full fetch group, so every
// hit returns FETCH_WIDTH words. Hits answer one cycle after the request. A
// miss raises icache_stall, issues a single line-aligned refill request,
// installs the returned line and forwards it to fetch in the same edge.
//
// Parameters:
//   INDEX_BITS     log2 of the line count (default 6 -> 64 lines)
//   FETCH_WIDTH    words per fetch group / cache line
//   CPU_ADDR_BITS  byte address width
//   CPU_DATA_BITS  instruction word width
//   (the last three mirror the uarch/ISA package values of the core)
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   icache_addr/re     fetch request (offset bits ignored)
//   icache_dout/_val   fetch group (word 0 in LSBs), one-cycle valid pulse
//   icache_stall       miss in progress; requests are dropped while high
//   mem_req_addr/val   line-aligned refill request, held until mem_req_rdy
//   mem_req_rdy        backing memory accepts the request
//   mem_resp_data/val  refill line, single beat
//
// Optional feature (macro ICACHE_PERF_EN):
//   adds perf_hits / perf_misses, 32-bit saturating counters cleared on rst.
// -----------------------------------------------------------------------------
module icache_ctrl #(
  parameter int INDEX_BITS    = 6,
  parameter int FETCH_WIDTH   = 2,
  parameter int CPU_ADDR_BITS = 32,
  parameter int CPU_DATA_BITS = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [CPU_ADDR_BITS-1:0]             icache_addr,
  input  logic                                 icache_re,
  output logic [FETCH_WIDTH*CPU_DATA_BITS-1:0] icache_dout,
  output logic                                 icache_dout_val,
  output logic                                 icache_stall,
  output logic [CPU_ADDR_BITS-1:0]             mem_req_addr,
  output logic                                 mem_req_val,
  input  logic                                 mem_req_rdy,
  input  logic [FETCH_WIDTH*CPU_DATA_BITS-1:0] mem_resp_data,
  input  logic                                 mem_resp_val
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]                          perf_hits,
  output logic [31:0]                          perf_misses
`endif
);

  localparam int OFF_BITS = $clog2(FETCH_WIDTH * 4);
  localparam int TAG_BITS = CPU_ADDR_BITS - INDEX_BITS - OFF_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int LINE_W   = FETCH_WIDTH * CPU_DATA_BITS;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] MISS_REQ  = 2'd1;
  localparam logic [1:0] MISS_WAIT = 2'd2;

  // ---------------------------------------------------------------------------
  // Storage: flop arrays, read combinationally so a hit resolves in the
  // request cycle and the result is registered once on the way out.
  // ---------------------------------------------------------------------------
  logic                valid_mem [LINES];
  logic [TAG_BITS-1:0] tag_mem   [LINES];
  logic [LINE_W-1:0]   data_mem  [LINES];

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  logic [1:0]               state_reg,    state_next;
  logic [LINE_W-1:0]        dout_reg,     dout_next;
  logic                     dout_val_reg, dout_val_next;
  logic                     stall_reg,    stall_next;
  logic                     req_val_reg,  req_val_next;
  logic [CPU_ADDR_BITS-1:0] req_addr_reg, req_addr_next;

  // ---------------------------------------------------------------------------
  // Request decode and lookup
  // ---------------------------------------------------------------------------
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;
  logic                  lookup_hit;
  logic                  req_fire;
  logic                  fill_fire;
  logic [INDEX_BITS-1:0] fill_idx;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  addr_off_unused;

  assign req_idx    = icache_addr[OFF_BITS+INDEX_BITS-1:OFF_BITS];
  assign req_tag    = icache_addr[CPU_ADDR_BITS-1 -: TAG_BITS];
  assign lookup_hit = valid_mem[req_idx] && (tag_mem[req_idx] == req_tag);

  // The byte offset within a group never matters: a line is a whole group.
  assign addr_off_unused = ^icache_addr[OFF_BITS-1:0];

  // Requests only count in IDLE; anything presented during a miss is dropped.
  assign req_fire  = (state_reg == IDLE) && icache_re;
  assign fill_fire = (state_reg == MISS_WAIT) && mem_resp_val;

  // The refill address register already carries the index and tag of the
  // line being fetched, so no separate miss index/tag latch is needed.
  assign fill_idx = req_addr_reg[OFF_BITS+INDEX_BITS-1:OFF_BITS];
  assign fill_tag = req_addr_reg[CPU_ADDR_BITS-1 -: TAG_BITS];

  // ---------------------------------------------------------------------------
  // Per-line storage update. Only valid bits are reset; tag and data are
  // qualified by valid and so can stay unreset.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_line
      logic line_we;
      assign line_we = fill_fire && (fill_idx == INDEX_BITS'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_mem[gi] <= 1'b0;
        end else if (line_we) begin
          valid_mem[gi] <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (line_we) begin
          tag_mem[gi]  <= fill_tag;
          data_mem[gi] <= mem_resp_data;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    dout_next     = dout_reg;
    dout_val_next = 1'b0;           // valid is a pulse, never held
    stall_next    = stall_reg;
    req_val_next  = req_val_reg;
    req_addr_next = req_addr_reg;

    case (state_reg)
      IDLE: begin
        if (icache_re) begin
          if (lookup_hit) begin
            dout_next     = data_mem[req_idx];
            dout_val_next = 1'b1;
          end else begin
            req_addr_next = {icache_addr[CPU_ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
            req_val_next  = 1'b1;
            stall_next    = 1'b1;
            state_next    = MISS_REQ;
          end
        end
      end

      MISS_REQ: begin
        // Address and valid stay put until the memory takes the request.
        if (mem_req_rdy) begin
          req_val_next = 1'b0;
          state_next   = MISS_WAIT;
        end
      end

      MISS_WAIT: begin
        // Install and forward in the same edge; the line is visible to a
        // request presented in the very next cycle.
        if (mem_resp_val) begin
          dout_next     = mem_resp_data;
          dout_val_next = 1'b1;
          stall_next    = 1'b0;
          state_next    = IDLE;
        end
      end

      default: begin
        req_val_next = 1'b0;
        stall_next   = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      dout_reg     <= '0;
      dout_val_reg <= 1'b0;
      stall_reg    <= 1'b0;
      req_val_reg  <= 1'b0;
      req_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      dout_reg     <= dout_next;
      dout_val_reg <= dout_val_next;
      stall_reg    <= stall_next;
      req_val_reg  <= req_val_next;
      req_addr_reg <= req_addr_next;
    end
  end

  assign icache_dout     = dout_reg;
  assign icache_dout_val = dout_val_reg;
  assign icache_stall    = stall_reg;
  assign mem_req_val     = req_val_reg;
  assign mem_req_addr    = req_addr_reg;

`ifdef ICACHE_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters: saturating, so a long run never wraps to a small
  // misleading value.
  // ---------------------------------------------------------------------------
  logic [31:0] perf_hits_reg;
  logic [31:0] perf_misses_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits_reg   <= '0;
      perf_misses_reg <= '0;
    end else begin
      if (req_fire && lookup_hit && (perf_hits_reg != 32'hFFFF_FFFF)) begin
        perf_hits_reg <= perf_hits_reg + 32'd1;
      end
      if (req_fire && !lookup_hit && (perf_misses_reg != 32'hFFFF_FFFF)) begin
        perf_misses_reg <= perf_misses_reg + 32'd1;
      end
    end
  end

  assign perf_hits   = perf_hits_reg;
  assign perf_misses = perf_misses_reg;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icache_ctrl
//
// Scoreboard bench for icache_ctrl. A driver issues fetch requests, looks each
// one up in an abstract cache model (valid/tag per index computed with plain
// division/modulo) and pushes the expected response. A monitor pops and
// compares whenever icache_dout_val is high. A memory responder checks each
// refill request against the queue of expected miss addresses and answers
// with deterministic per-line data after randomized backpressure and delay.
// -----------------------------------------------------------------------------
module tb_icache_ctrl;

  localparam int IB    = 6;
  localparam int FW    = 2;
  localparam int AB    = 32;
  localparam int DB    = 32;
  localparam int LB    = FW * 4;
  localparam int LINES = 1 << IB;
  localparam int LW    = FW * DB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AB-1:0] icache_addr = '0;
  logic          icache_re = 1'b0;
  logic [LW-1:0] icache_dout;
  logic          icache_dout_val;
  logic          icache_stall;
  logic [AB-1:0] mem_req_addr;
  logic          mem_req_val;
  logic          mem_req_rdy = 1'b0;
  logic [LW-1:0] mem_resp_data = '0;
  logic          mem_resp_val = 1'b0;
`ifdef ICACHE_PERF_EN
  logic [31:0]   perf_hits;
  logic [31:0]   perf_misses;
`endif

  icache_ctrl #(
    .INDEX_BITS(IB), .FETCH_WIDTH(FW), .CPU_ADDR_BITS(AB), .CPU_DATA_BITS(DB)
  ) dut (
    .clk(clk), .rst(rst),
    .icache_addr(icache_addr), .icache_re(icache_re),
    .icache_dout(icache_dout), .icache_dout_val(icache_dout_val),
    .icache_stall(icache_stall),
    .mem_req_addr(mem_req_addr), .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_resp_data(mem_resp_data), .mem_resp_val(mem_resp_val)
`ifdef ICACHE_PERF_EN
    , .perf_hits(perf_hits), .perf_misses(perf_misses)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [LW-1:0] data;
    bit            is_miss;
    int            cyc;
  } exp_t;

  exp_t          exp_q[$];
  logic [AB-1:0] miss_q[$];

  int resp_cyc = 0;
  int last_fill_cyc = 0;
  int last_miss_issue_cyc = 0;
  bit last_was_miss = 1'b0;
  bit auto_mem = 1'b0;
  int bp_lo = 0, bp_hi = 0, dly_lo = 0, dly_hi = 0;

  // Abstract cache model
  bit          model_valid [LINES];
  int unsigned model_tag   [LINES];
  int unsigned model_hits = 0;
  int unsigned model_misses = 0;

  // Backing memory content: fixed, distinct per line and per word.
  function automatic logic [LW-1:0] line_data(input logic [AB-1:0] line_addr);
    logic [LW-1:0] d;
    for (int w = 0; w < FW; w++)
      d[w*DB +: DB] = (line_addr * 32'h9E37_79B1) ^ (32'(w + 1) * 32'h0101_0101) ^ 32'hC0DE_0000;
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) model_valid[i] = 1'b0;
    model_hits = 0;
    model_misses = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"},     64'(icache_dout), 64'd0);
    check({tag, "_dout_val"}, 64'(icache_dout_val), 64'd0);
    check({tag, "_stall"},    64'(icache_stall), 64'd0);
    check({tag, "_req_val"},  64'(mem_req_val), 64'd0);
    check({tag, "_req_addr"}, 64'(mem_req_addr), 64'd0);
`ifdef ICACHE_PERF_EN
    check({tag, "_perf_hits"},   64'(perf_hits), 64'd0);
    check({tag, "_perf_misses"}, 64'(perf_misses), 64'd0);
`endif
  endtask

  // Present one request (caller is at a negedge) and record what must follow.
  task automatic drive_req(input logic [AB-1:0] addr);
    int unsigned a    = addr;
    int unsigned idx  = (a / LB) % LINES;
    int unsigned tg   = a / (LB * LINES);
    int unsigned line = (a / LB) * LB;
    bit          hit  = model_valid[idx] && (model_tag[idx] == tg);
    exp_t        e;
    e.data    = line_data(line);
    e.is_miss = !hit;
    e.cyc     = cyc + 1;
    exp_q.push_back(e);
    if (hit) begin
      model_hits++;
    end else begin
      model_misses++;
      model_valid[idx] = 1'b1;
      model_tag[idx]   = tg;
      miss_q.push_back(line);
      last_miss_issue_cyc = cyc;
    end
    icache_addr   = addr;
    icache_re     = 1'b1;
    last_was_miss = !hit;
    $display("req  cyc=%0d addr=%h %s", cyc, addr, hit ? "hit" : "miss");
  endtask

  // One fetch: on a miss, scribble dropped requests during the stall and
  // re-present the same address in the first cycle after stall falls.
  task automatic issue(input logic [AB-1:0] addr);
    bit done;
    @(negedge clk);
    check("stall_before_req", 64'(icache_stall), 64'd0);
    drive_req(addr);
    if (last_was_miss) begin
      @(negedge clk);
      check("stall_after_miss", 64'(icache_stall), 64'd1);
      check("req_val_after_miss", 64'(mem_req_val), 64'd1);
      done = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if (!icache_stall) begin
          done = 1'b1;
          break;
        end
        icache_re   = 1'($urandom_range(1, 0));
        icache_addr = $urandom;
        @(negedge clk);
      end
      if (!done) begin
        n_vec++;
        n_err++;
        $display("FAIL stall_timeout @cyc %0d: stall still %0d, required 0", cyc, icache_stall);
      end
      drive_req(addr);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    icache_re = 1'b0;
  endtask

  // Monitor: compare every presented group against the scoreboard.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (icache_dout_val) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_dout_val @cyc %0d: got dout_val=1 data=%h required no response", cyc, icache_dout);
        end else begin
          e = exp_q.pop_front();
          $display("resp cyc=%0d data=%h %s", cyc, icache_dout, e.is_miss ? "fill" : "hit");
          check("dout_data", 64'(icache_dout), 64'(e.data));
          if (e.is_miss) begin
            check("fill_timing", 64'(cyc), 64'(resp_cyc + 1));
            last_fill_cyc = cyc;
          end else begin
            check("hit_timing", 64'(cyc), 64'(e.cyc));
          end
        end
      end
    end
  end

  // Backing memory responder.
  initial begin : responder
    logic [AB-1:0] ea;
    int nbp, nd;
    forever begin
      @(negedge clk);
      if (auto_mem && mem_req_val) begin
        if (miss_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_mem_req @cyc %0d: got mem_req_val=1 addr=%h required no request", cyc, mem_req_addr);
          ea = mem_req_addr;
        end else begin
          ea = miss_q.pop_front();
        end
        check("mem_req_addr", 64'(mem_req_addr), 64'(ea));
        nbp = $urandom_range(bp_hi, bp_lo);
        for (int i = 0; i < nbp; i++) begin
          mem_req_rdy = 1'b0;
          @(negedge clk);
          check("req_val_held", 64'(mem_req_val), 64'd1);
          check("req_addr_held", 64'(mem_req_addr), 64'(ea));
        end
        mem_req_rdy = 1'b1;
        @(negedge clk);
        mem_req_rdy = 1'b0;
        check("req_val_drop", 64'(mem_req_val), 64'd0);
        nd = $urandom_range(dly_hi, dly_lo);
        for (int i = 0; i < nd; i++) @(negedge clk);
        mem_resp_data = line_data(ea);
        mem_resp_val  = 1'b1;
        resp_cyc      = cyc;
        @(negedge clk);
        mem_resp_val  = 1'b0;
        mem_resp_data = '0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // Cold miss with minimum memory latency, then the re-presented hit.
    auto_mem = 1'b1;
    bp_lo = 0; bp_hi = 0; dly_lo = 0; dly_hi = 0;
    issue(32'h0000_0100);
    idle();
    check("cold_miss_latency", 64'(last_fill_cyc - last_miss_issue_cyc), 64'd3);
`ifdef ICACHE_PERF_EN
    check("perf_hits_cold", 64'(perf_hits), 64'(model_hits));
    check("perf_misses_cold", 64'(perf_misses), 64'(model_misses));
    check("perf_hits_one", 64'(perf_hits), 64'd1);
`endif

    // Hits in the same group, then back-to-back hits on four warmed groups.
    issue(32'h0000_0100);
    issue(32'h0000_0104);
    idle();
    issue(32'h0000_0108);
    issue(32'h0000_0110);
    issue(32'h0000_0118);
    idle();
    issue(32'h0000_0100);
    issue(32'h0000_0108);
    issue(32'h0000_0110);
    issue(32'h0000_0118);
    idle();

    // Conflict on the same index, then the original line misses again.
    issue(32'h0000_0100 + 32'(LINES * LB));
    issue(32'h0000_0100);
    idle();

    // Five cycles of backpressure with a slow response.
    bp_lo = 5; bp_hi = 5; dly_lo = 2; dly_hi = 2;
    issue(32'h0000_0400);
    idle();

    // Reset in MISS_WAIT, then a stray response that must be ignored.
    auto_mem = 1'b0;
    repeat (2) idle();
    @(negedge clk);
    icache_addr = 32'h0000_0200;
    icache_re   = 1'b1;
    @(negedge clk);
    icache_re = 1'b0;
    check("rstmiss_req_val", 64'(mem_req_val), 64'd1);
    mem_req_rdy = 1'b1;
    @(negedge clk);
    mem_req_rdy = 1'b0;
    check("rstmiss_stall", 64'(icache_stall), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_zero("rst_mid_miss");
    mem_resp_data = ~line_data(32'h0000_0200);
    mem_resp_val  = 1'b1;
    @(negedge clk);
    mem_resp_val  = 1'b0;
    mem_resp_data = '0;
    check_zero("stray_resp");
    @(negedge clk);
    check_zero("stray_resp2");
    auto_mem = 1'b1;
    bp_lo = 0; bp_hi = 0; dly_lo = 0; dly_hi = 0;
    issue(32'h0000_0200);   // must miss: line was never installed
    idle();

    // Randomized traffic over a few tags and indices for hits and conflicts.
    bp_lo = 0; bp_hi = 4; dly_lo = 0; dly_hi = 3;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(3, 0) == 0) begin
        idle();
      end else begin
        issue((32'($urandom_range(3, 0)) << (IB + 3)) |
              (32'($urandom_range(7, 0)) << 3) |
              32'($urandom_range(7, 0)));
      end
    end
    repeat (6) idle();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("miss_queue_drained", 64'(miss_q.size()), 64'd0);
`ifdef ICACHE_PERF_EN
    check("perf_hits_final", 64'(perf_hits), 64'(model_hits));
    check("perf_misses_final", 64'(perf_misses), 64'(model_misses));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
